// File: rtl/alu_mdu_if.sv
// Execute-stage operation/result bundle for alu_mdu.
// Handshake: a beat moves on any clock edge where valid && ready. The producer holds
// valid and its payload unchanged until that edge. Ready may depend on valid, but valid
// must never depend on ready.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [19:0]      alu_op;
    logic [WIDTH-1:0] alu_src1;
    logic [WIDTH-1:0] alu_src2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;

    modport master (
        output in_valid, alu_op, alu_src1, alu_src2, out_ready,
        input  in_ready, out_valid, alu_result
    );

    modport slave (
        input  in_valid, alu_op, alu_src1, alu_src2, out_ready,
        output in_ready, out_valid, alu_result
    );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: LoongArch EX-stage ALU with multiply and radix-2 restoring divide/modulo.
// Define ALU_MUL_EN to build the multiplier; without it MUL/MULH/MULHU return 0 in one cycle.
module alu_mdu #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    alu_mdu_if.slave   bus,
    output logic [1:0] dbg_state
);
`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2, ST_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DIV = 2'd2, ST_DONE = 2'd3} state_t;
`endif

    state_t state_q, state_d;

    logic [WIDTH-1:0] a, b;
    logic [SHW-1:0]   shamt;
    logic             accept, div_op, mul_op, div_last;
    logic [WIDTH-1:0] simple_res;

    logic             sgn_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] div_quo, div_rem, div_dvs;
    logic [SHW-1:0]   div_cnt;
    logic             div_neg_q, div_neg_r, div_mod, div_zero;
    logic [WIDTH:0]   div_part, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] quo_next, rem_next, quo_fix, rem_fix, div_res;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_a, mul_b, prod;
    logic               mul_hi;
`endif

    assign a      = bus.alu_src1;
    assign b      = bus.alu_src2;
    assign shamt  = b[SHW-1:0];
    assign div_op = |bus.alu_op[19:16];
    assign mul_op = |bus.alu_op[15:13];

    // DONE may hand off its result and take a new operation in the same cycle.
    assign bus.in_ready  = !reset && !flush &&
                           (state_q == ST_IDLE || (state_q == ST_DONE && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == ST_DONE);
    assign dbg_state     = state_q;

    always_comb begin
        simple_res = '0;
        if (bus.alu_op[0])  simple_res = a + b;
        if (bus.alu_op[1])  simple_res = a - b;
        if (bus.alu_op[2])  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        if (bus.alu_op[3])  simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
        if (bus.alu_op[4])  simple_res = a & b;
        if (bus.alu_op[5])  simple_res = ~(a | b);
        if (bus.alu_op[6])  simple_res = a | b;
        if (bus.alu_op[7])  simple_res = a ^ b;
        if (bus.alu_op[8])  simple_res = a << shamt;
        if (bus.alu_op[9])  simple_res = a >> shamt;
        if (bus.alu_op[10]) simple_res = $signed(a) >>> shamt;
        if (bus.alu_op[11]) simple_res = b;
        if (bus.alu_op[12]) simple_res = {{(WIDTH-1){1'b0}}, (a == b)};
        if (mul_op)         simple_res = '0;
    end

    // Divide runs on magnitudes; signs are reapplied on the final iteration.
    always_comb begin
        sgn_div  = bus.alu_op[16] | bus.alu_op[17];
        a_neg    = sgn_div & a[WIDTH-1];
        b_neg    = sgn_div & b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_part = {div_rem, div_quo[WIDTH-1]};
        div_diff = div_part - {1'b0, div_dvs};
        div_ge   = !div_diff[WIDTH];
        rem_next = div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0];
        quo_next = {div_quo[WIDTH-2:0], div_ge};
        quo_fix  = div_zero ? '1 : (div_neg_q ? -quo_next : quo_next);
        rem_fix  = div_neg_r ? -rem_next : rem_next;
        div_res  = div_mod ? rem_fix : quo_fix;
    end

    assign div_last = &div_cnt;

`ifdef ALU_MUL_EN
    assign mul_a = {{WIDTH{bus.alu_op[14] & a[WIDTH-1]}}, a};
    assign mul_b = {{WIDTH{bus.alu_op[14] & b[WIDTH-1]}}, b};
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_DONE;
`ifdef ALU_MUL_EN
                    if (mul_op) state_d = ST_MUL;
`endif
                    if (div_op) state_d = ST_DIV;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: state_d = ST_DONE;
`endif
            ST_DIV: if (div_last) state_d = ST_DONE;
            ST_DONE: begin
                if (accept) begin
                    state_d = ST_DONE;
`ifdef ALU_MUL_EN
                    if (mul_op) state_d = ST_MUL;
`endif
                    if (div_op) state_d = ST_DIV;
                end else if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.alu_result <= '0;
            div_quo        <= '0;
            div_rem        <= '0;
            div_dvs        <= '0;
            div_cnt        <= '0;
            div_neg_q      <= 1'b0;
            div_neg_r      <= 1'b0;
            div_mod        <= 1'b0;
            div_zero       <= 1'b0;
`ifdef ALU_MUL_EN
            prod           <= '0;
            mul_hi         <= 1'b0;
`endif
        end else if (accept) begin
            if (div_op) begin
                div_quo   <= a_mag;
                div_rem   <= '0;
                div_dvs   <= b_mag;
                div_cnt   <= '0;
                div_neg_q <= a_neg ^ b_neg;
                div_neg_r <= a_neg;
                div_mod   <= bus.alu_op[17] | bus.alu_op[19];
                div_zero  <= (b == '0);
            end
`ifdef ALU_MUL_EN
            else if (mul_op) begin
                prod   <= mul_a * mul_b;
                mul_hi <= bus.alu_op[14] | bus.alu_op[15];
            end
`endif
            else begin
                bus.alu_result <= simple_res;
            end
        end else if (state_q == ST_DIV) begin
            div_quo <= quo_next;
            div_rem <= rem_next;
            div_cnt <= div_cnt + SHW'(1);
            if (div_last) bus.alu_result <= div_res;
        end
`ifdef ALU_MUL_EN
        else if (state_q == ST_MUL) begin
            bus.alu_result <= mul_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
        end
`endif
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed cases, randomized ops against a reference model,
// backpressure, flush and reset-during-divide, plus a WIDTH=64 instance.
module tb_alu_mdu;
    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] dbg32, dbg64;
    int         tests = 0;
    int         fails = 0;
    logic [31:0] exp_q[$];

`ifdef ALU_MUL_EN
    localparam int LAT_MUL = 2;
`else
    localparam int LAT_MUL = 1;
`endif

    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(32)) bus32();
    alu_mdu_if #(.WIDTH(64)) bus64();

    alu_mdu #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .flush(flush), .bus(bus32), .dbg_state(dbg32));
    alu_mdu #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .flush(flush), .bus(bus64), .dbg_state(dbg64));

    always @(posedge clk) begin
        if (bus32.in_valid && !$onehot0(bus32.alu_op)) begin
            fails++;
            $error("FAIL onehot32: alu_op %h", bus32.alu_op);
        end
        if (bus64.in_valid && !$onehot0(bus64.alu_op)) begin
            fails++;
            $error("FAIL onehot64: alu_op %h", bus64.alu_op);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference results straight from the instruction definitions (k==20 means alu_op==0).
    function automatic logic [31:0] model(input int k, input logic [31:0] a, input logic [31:0] b);
        int          ia, ib;
        longint      sp;
        logic [63:0] up;
        ia = a;
        ib = b;
        sp = longint'(ia) * longint'(ib);
        up = {32'd0, a} * {32'd0, b};
        case (k)
            0:  return a + b;
            1:  return a - b;
            2:  return (ia < ib) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return ia >>> b[4:0];
            11: return b;
            12: return (a == b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
            13: return sp[31:0];
            14: return sp[63:32];
            15: return up[63:32];
`else
            13, 14, 15: return 32'd0;
`endif
            16: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            17: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            18: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            19: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(input int k);
        if (k >= 16 && k <= 19) return 33;
        if (k >= 13 && k <= 15) return LAT_MUL;
        return 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic run32(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input string tag);
        int lat;
        bit got;
        exp_q.push_back(exp);
        bus32.alu_op   = (k < 20) ? (20'd1 << k) : 20'd0;
        bus32.alu_src1 = a;
        bus32.alu_src2 = b;
        bus32.in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = bus32.in_ready;
        end
        check({tag, ":accept"}, 64'(got), 64'd1);
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        bus32.alu_src1 = $urandom;
        bus32.alu_src2 = $urandom;
        lat = 1;
        while (!bus32.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ":res"}, 64'(bus32.alu_result), 64'(exp_q.pop_front()));
        check({tag, ":lat"}, 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
    endtask

    task automatic run64(input int k, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat, input string tag);
        int lat;
        bit got;
        bus64.alu_op   = 20'd1 << k;
        bus64.alu_src1 = a;
        bus64.alu_src2 = b;
        bus64.in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = bus64.in_ready;
        end
        check({tag, ":accept"}, 64'(got), 64'd1);
        @(posedge clk); #1;
        bus64.in_valid = 1'b0;
        bus64.alu_src1 = {$urandom, $urandom};
        lat = 1;
        while (!bus64.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ":res"}, bus64.alu_result, exp);
        check({tag, ":lat"}, 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
    endtask

    initial begin
        int  k;
        bit  seen;
        logic [31:0] ra, rb;

        reset = 1'b1;
        flush = 1'b0;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; bus32.alu_op = 20'd0;
        bus32.alu_src1 = '0;   bus32.alu_src2 = '0;
        bus64.in_valid = 1'b0; bus64.out_ready = 1'b1; bus64.alu_op = 20'd0;
        bus64.alu_src1 = '0;   bus64.alu_src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst:in_ready", 64'(bus32.in_ready), 64'd0);
        check("rst:out_valid", 64'(bus32.out_valid), 64'd0);
        check("rst:result", 64'(bus32.alu_result), 64'd0);
        check("rst:result64", bus64.alu_result, 64'd0);
        reset = 1'b0;
        #1;
        check("rst:ready_after", 64'(bus32.in_ready), 64'd1);
        @(posedge clk); #1;

        run32(0,  32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 1, "add_ovf");
        run32(2,  32'hFFFF_FFFF, 32'd1,        32'd1,         1, "slt");
        run32(3,  32'hFFFF_FFFF, 32'd1,        32'd0,         1, "sltu");
        run32(10, 32'h8000_0000, 32'd4,        32'hF800_0000, 1, "sra");
        run32(20, 32'h1234_5678, 32'h1,        32'd0,         1, "op_zero");
        run32(16, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, "div");
        run32(17, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, "mod");
        run32(18, 32'd7,         32'd0,        32'hFFFF_FFFF, 33, "divu0");
        run32(19, 32'd7,         32'd0,        32'd7,         33, "modu0");
        run32(16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "div_ovf");
        run32(17, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        33, "mod_ovf");
`ifdef ALU_MUL_EN
        run32(14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         2, "mulh");
        run32(15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mulhu");
        run32(13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         2, "mul");
`else
        run32(13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1, "mul_off");
`endif

        for (int n = 0; n < 60; n++) begin
            k  = $urandom_range(0, 20);
            ra = pick();
            rb = pick();
            run32(k, ra, rb, model(k, ra, rb), lat_of(k), $sformatf("rand%0d_op%0d", n, k));
        end

        // Backpressure, then simultaneous result and operation handshakes.
        bus32.out_ready = 1'b0;
        bus32.alu_op = 20'd1; bus32.alu_src1 = 32'd3; bus32.alu_src2 = 32'd4;
        bus32.in_valid = 1'b1;
        @(negedge clk);
        check("bp:accept", 64'(bus32.in_ready), 64'd1);
        @(posedge clk); #1;
        bus32.in_valid = 1'b0; bus32.alu_src1 = $urandom; bus32.alu_src2 = $urandom;
        check("bp:valid", 64'(bus32.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp:hold", 64'(bus32.alu_result), 64'd7);
            check("bp:in_ready", 64'(bus32.in_ready), 64'd0);
        end
        bus32.alu_src1 = 32'd10; bus32.alu_src2 = 32'd20;
        bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
        #1;
        check("bp:both_ready", 64'(bus32.in_ready), 64'd1);
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        check("bp:b2b_valid", 64'(bus32.out_valid), 64'd1);
        check("bp:b2b_res", 64'(bus32.alu_result), 64'd30);
        @(posedge clk); #1;

        // Flush while idle with an offered op: nothing is accepted.
        flush = 1'b1;
        bus32.alu_op = 20'd1; bus32.alu_src1 = 32'd5; bus32.alu_src2 = 32'd6;
        bus32.in_valid = 1'b1;
        #1;
        check("flush:in_ready", 64'(bus32.in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; bus32.in_valid = 1'b0;
        check("flush:no_accept", 64'(bus32.out_valid), 64'd0);

        // Flush at divide cycle 10.
        bus32.alu_op = 20'd1 << 16; bus32.alu_src1 = 32'd1000; bus32.alu_src2 = 32'd3;
        bus32.in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush:state", 64'(dbg32), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus32.out_valid) seen = 1'b1;
        end
        check("flush:no_result", 64'(seen), 64'd0);
        run32(18, 32'd100, 32'd7, 32'd14, 33, "divu_after_flush");

        // Reset in the middle of a divide.
        bus32.alu_op = 20'd1 << 16; bus32.alu_src1 = 32'd1000; bus32.alu_src2 = 32'd3;
        bus32.in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rstmid:in_ready_hi", 64'(bus32.in_ready), 64'd0);
        @(posedge clk); #1;
        check("rstmid:out_valid", 64'(bus32.out_valid), 64'd0);
        check("rstmid:result", 64'(bus32.alu_result), 64'd0);
        check("rstmid:state", 64'(dbg32), 64'd0);
        reset = 1'b0;
        #1;
        run32(19, 32'd100, 32'd7, 32'd2, 33, "modu_after_reset");

        // WIDTH = 64 instance.
        run64(8,  64'd1,            64'd63,   64'h8000_0000_0000_0000, 1,  "w64_sll63");
        run64(9,  64'h1234_5678,    64'h40,   64'h1234_5678,           1,  "w64_srl64");
        run64(10, 64'h8000_0000_0000_0000, 64'd8, 64'hFF80_0000_0000_0000, 1, "w64_sra");
        run64(18, 64'd100,          64'd7,    64'd14,                  65, "w64_divu");
        run64(16, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "w64_div");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
